// File: rtl/frame_uart_tx.sv
// frame_uart_tx: streams a stored 8-bit frame from BRAM over an 8N1 UART, address 0 first.
module frame_uart_tx #(
  parameter int CLKS_PER_BIT = 564,
  parameter int NUM_PIXELS   = 256000,
  parameter int ADDR_W       = 18,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        bram_state,
  input  logic [7:0]        bram_dout,
  output logic [ADDR_W-1:0] tx_counter,
  output logic              transmitting,
  output logic              uart_txd,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2((CLKS_PER_BIT > RD_LAT ? CLKS_PER_BIT : RD_LAT) + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP, FIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              start_prev_q;
  logic              accept, baud_last, fetch_last, last_pix;
  assign accept     = start && !start_prev_q && state_q == IDLE && bram_state == 2'b11;
  assign baud_last  = baud_q == BW'(CLKS_PER_BIT - 1);
  assign fetch_last = baud_q == BW'(RD_LAT - 1);
  assign last_pix   = cnt_q == ADDR_W'(NUM_PIXELS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        state_d = accept ? FETCH : IDLE;
      end
      FETCH: if (fetch_last) begin
        baud_d  = '0;
        state_d = LATCH;
      end
      LATCH: begin
        baud_d  = '0;
        shift_d = bram_dout;
        state_d = START;
      end
      START: if (baud_last) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_last) begin
        baud_d  = '0;
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_last) begin
        baud_d  = '0;
        state_d = last_pix ? FIN : FETCH;
        cnt_d   = last_pix ? '0 : cnt_q + ADDR_W'(1);
      end
      FIN: begin
        baud_d  = '0;
        state_d = IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
    // abort wins over every transition, including the FIN cycle
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      baud_d  = '0;
      bit_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      start_prev_q <= start;
    end
  end
  assign tx_counter   = cnt_q;
  assign busy         = state_q != IDLE;
  assign transmitting = busy && state_q != FIN;
  assign done         = state_q == FIN && !abort;
  // line forced idle the moment abort is seen, truncating any byte in flight
  assign uart_txd     = abort || !(state_q == START || (state_q == DATA && !shift_q[0]));
endmodule

// File: tb/tb_frame_uart_tx.sv
// tb_frame_uart_tx: random frames through frame_uart_tx, decoded by a UART receiver and scored against queued BRAM contents.
module tb_frame_uart_tx;
  localparam int CPB = 4, N = 4, RDL = 2, AW = 18;
  localparam int PERIOD = 10 * CPB + RDL + 1;
  logic          clk = 0, rst_n, start, abort;
  logic [1:0]    bram_state;
  logic [7:0]    bram_dout, d1, d2;
  logic [AW-1:0] tx_counter;
  logic          transmitting, uart_txd, busy, done;
  logic [7:0]    mem [N];
  logic [7:0]    exp_q [$];
  int            checks = 0, errors = 0;
  int            frames_started = 0, frames_done = 0, frame_bytes = 0;
  int            cyc_n = 0, last_t0 = 0, rx_t = 0;
  bit            rx_busy = 0, prev_txd = 1, done_exp, live;
  logic [7:0]    rx_byte, e;

  frame_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_PIXELS(N), .ADDR_W(AW), .RD_LAT(RDL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bram_state(bram_state),
    .bram_dout(bram_dout), .tx_counter(tx_counter), .transmitting(transmitting),
    .uart_txd(uart_txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= mem[tx_counter[1:0]];
    d2 <= d1;
  end
  assign bram_dout = d2;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // receiver and scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 0;
      prev_txd = 1;
      frame_bytes = 0;
    end else begin
      cyc_n++;
      live = frames_done < frames_started;
      done_exp = live && frame_bytes == N && cyc_n == last_t0 + 10 * CPB;
      check(int'(tx_counter) <= N - 1, "addr_range", int'(tx_counter), N - 1);
      check(transmitting == (live && !done_exp), "transmitting", int'(transmitting), int'(live && !done_exp));
      if (done || done_exp) begin
        check(done == done_exp, "done_pulse", int'(done), int'(done_exp));
        if (done) begin
          check(tx_counter == 0, "done_addr", int'(tx_counter), 0);
          frames_done++;
          frame_bytes = 0;
        end
      end
      if (abort) begin
        rx_busy = 0;
        frame_bytes = 0;
      end else if (!rx_busy) begin
        if (prev_txd && !uart_txd) begin
          rx_busy = 1;
          rx_t = 0;
          check(int'(tx_counter) == frame_bytes, "byte_addr", int'(tx_counter), frame_bytes);
          if (frame_bytes > 0) check(cyc_n - last_t0 == PERIOD, "byte_period", cyc_n - last_t0, PERIOD);
          last_t0 = cyc_n;
        end
      end else begin
        rx_t++;
        if (rx_t == CPB / 2) check(uart_txd == 0, "start_bit", int'(uart_txd), 0);
        else if (rx_t == 9 * CPB + CPB / 2) begin
          check(uart_txd == 1, "stop_bit", int'(uart_txd), 1);
          check(exp_q.size() > 0, "extra_byte", int'(rx_byte), -1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(rx_byte == e, "data_byte", int'(rx_byte), int'(e));
          end
          frame_bytes++;
          rx_busy = 0;
        end else if (rx_t > CPB && (rx_t - CPB / 2) % CPB == 0)
          rx_byte[(rx_t - CPB / 2) / CPB - 1] = uart_txd;
      end
      prev_txd = uart_txd;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1;
    cyc(1);
    frames_started++;
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (frames_done < frames_started && n < 2000) begin
      cyc(1);
      n++;
    end
    check(frames_done == frames_started, name, frames_done, frames_started);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_rx(input int nb, input string name);
    int n = 0;
    while (!(frame_bytes == nb && rx_busy) && n < 1000) begin
      cyc(1);
      n++;
    end
    check(frame_bytes == nb && rx_busy, name, frame_bytes, nb);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; bram_state = 0;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
    cyc(3);
    check(uart_txd == 1, "rst_txd", int'(uart_txd), 1);
    check(tx_counter == 0, "rst_addr", int'(tx_counter), 0);
    check(busy == 0, "rst_busy", int'(busy), 0);
    check(done == 0, "rst_done", int'(done), 0);
    check(transmitting == 0, "rst_transmitting", int'(transmitting), 0);
    rst_n = 1;
    cyc(2);
    // T1: fixed frame
    bram_state = 2'b11;
    kick();
    start = 0;
    wait_idle("t1_frame");
    check(frames_done == 1, "t1_count", frames_done, 1);
    check(tx_counter == 0 && busy == 0, "t1_idle", int'(busy), 0);
    // T2: edge while frame invalid is dropped
    bram_state = 2'b01;
    start = 1;
    cyc(6);
    check(busy == 0, "t2_dropped", int'(busy), 0);
    check(uart_txd == 1, "t2_txd", int'(uart_txd), 1);
    start = 0;
    cyc(2);
    bram_state = 2'b11;
    kick();
    start = 0;
    wait_idle("t2_frame");
    // T3: second edge during byte 1, start held high past done
    randomize_mem();
    kick();
    cyc(10);
    start = 0;
    cyc(55);
    start = 1;
    wait_idle("t3_frame");
    check(frames_done == 3, "t3_count", frames_done, 3);
    cyc(5);
    check(busy == 0, "t3_no_restart", int'(busy), 0);
    start = 0;
    cyc(2);
    // T4: abort inside DATA of byte 2
    randomize_mem();
    kick();
    start = 0;
    wait_rx(2, "t4_reach_byte2");
    cyc(CPB - 1 + int'($urandom_range(0, 8 * CPB - 1)));
    abort = 1;
    #1;
    check(uart_txd == 1, "abort_txd_now", int'(uart_txd), 1);
    cyc(1);
    abort = 0;
    check(busy == 0, "abort_busy", int'(busy), 0);
    check(transmitting == 0, "abort_transmitting", int'(transmitting), 0);
    check(uart_txd == 1, "abort_txd", int'(uart_txd), 1);
    check(tx_counter == 0, "abort_addr", int'(tx_counter), 0);
    frames_started--;
    exp_q.delete();
    cyc(20);
    check(frames_done == 3, "t4_no_done", frames_done, 3);
    kick();
    start = 0;
    wait_idle("t4_resend");
    // T5: async reset inside STOP of byte 0
    randomize_mem();
    kick();
    start = 0;
    wait_rx(0, "t5_reach_byte0");
    cyc(9 * CPB);
    #2;
    rst_n = 0;
    #1;
    check(uart_txd == 1, "t5_txd", int'(uart_txd), 1);
    check(tx_counter == 0, "t5_addr", int'(tx_counter), 0);
    check(busy == 0, "t5_busy", int'(busy), 0);
    check(transmitting == 0, "t5_transmitting", int'(transmitting), 0);
    frames_started--;
    exp_q.delete();
    cyc(2);
    rst_n = 1;
    cyc(2);
    kick();
    start = 0;
    wait_idle("t5_frame");
    // random frames; bram_state may leave READING_FRAME mid-frame
    repeat (6) begin
      randomize_mem();
      cyc(int'($urandom_range(1, 10)));
      bram_state = 2'b11;
      kick();
      cyc(int'($urandom_range(0, 60)));
      start = 0;
      bram_state = 2'($urandom_range(0, 3));
      wait_idle("rand_frame");
    end
    check(frames_done == frames_started, "final_count", frames_done, frames_started);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
